ps2_arrow_decoder: RTL and testbench



---
 rtl/ps2_codes_pkg.sv | 30 +++
 rtl/ps2_rx.sv | 166 ++++++++++++++++
 rtl/ps2_arrow_decoder.sv | 89 ++++++++
 tb/tb_ps2_arrow_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ps2_codes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_codes_pkg
// Brief    : PS/2 scan codes and receiver state encoding for the arrow decoder.
// Revision : 1.0
// ============================================================================
package ps2_codes_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Brief    : PS/2 frame receiver with synchronisers, clock glitch filter and
//            inter-edge watchdog.
// Revision : 1.0
// ============================================================================
module ps2_rx
  import ps2_codes_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_error
);

  localparam int                c_WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

  logic                  r_clk_s1, r_clk_s2;
  logic                  r_dat_s1, r_dat_s2;
  logic [FILTER_LEN-2:0] r_hist;
  logic                  r_fclk;
  logic                  r_fall;
  rx_state_t             r_state;
  logic [7:0]            r_shift;
  logic [2:0]            r_bit_cnt;
  logic                  r_par;
  logic [c_WDOG_W-1:0]   r_wdog;
  logic                  r_byte_valid;
  logic                  r_frame_error;

  logic [FILTER_LEN-1:0] w_win;
  logic                  w_all_low, w_all_high;
  rx_state_t             w_state_next;
  logic                  w_shift_en, w_par_en;
  logic                  w_valid_next, w_err_next;
  logic                  w_wdog_expired;

  // The window includes the sample arriving this clock, so the filtered level
  // and its fall strobe register together on the FILTER_LEN-th equal sample.
  assign w_win      = {r_hist, r_clk_s2};
  assign w_all_low  = ~|w_win;
  assign w_all_high = &w_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_hist   <= '1;
      r_fclk   <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_hist   <= w_win[FILTER_LEN-2:0];
      r_fall   <= r_fclk & w_all_low;
      if (w_all_low) begin
        r_fclk <= 1'b0;
      end else if (w_all_high) begin
        r_fclk <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_en     = 1'b0;
    w_par_en       = 1'b0;
    w_valid_next   = 1'b0;
    w_err_next     = 1'b0;
    w_wdog_expired = (r_state != RX_IDLE) && !r_fall && (r_wdog == c_WDOG_LAST);
    case (r_state)
      RX_IDLE: begin
        if (r_fall && !r_dat_s2) begin
          w_state_next = RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_fall) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_state_next = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (r_fall) begin
          w_par_en     = 1'b1;
          w_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_fall) begin
          w_state_next = RX_IDLE;
          if (odd_parity_ok(r_shift, r_par) && r_dat_s2) begin
            w_valid_next = 1'b1;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
    if (w_wdog_expired) begin
      w_state_next = RX_IDLE;
      w_shift_en   = 1'b0;
      w_par_en     = 1'b0;
      w_err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift       <= 8'h00;
      r_bit_cnt     <= 3'd0;
      r_par         <= 1'b0;
      r_wdog        <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_byte_valid  <= w_valid_next;
      r_frame_error <= w_err_next;
      if (r_state == RX_IDLE) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {r_dat_s2, r_shift[7:1]};
      end
      if (w_par_en) begin
        r_par <= r_dat_s2;
      end
      if ((r_state == RX_IDLE) || r_fall || w_wdog_expired) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + c_WDOG_W'(1);
      end
    end
  end

  assign o_byte        = r_shift;
  assign o_byte_valid  = r_byte_valid;
  assign o_frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: rtl/ps2_arrow_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_arrow_decoder
// Brief    : PS/2 keyboard to held arrow-key levels (make/break decoder).
// Revision : 1.0
// ============================================================================
module ps2_arrow_decoder
  import ps2_codes_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic kup,
  output logic kdown,
  output logic kleft,
  output logic kright,
  output logic frame_error
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_error;

  logic       r_ext, r_brk;
  logic       r_kup, r_kdown, r_kleft, r_kright;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk           (clock),
    .rst           (reset),
    .i_ps2_clk     (ps2_clk),
    .i_ps2_data    (ps2_data),
    .o_byte        (w_byte),
    .o_byte_valid  (w_byte_valid),
    .o_frame_error (w_frame_error)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_kup    <= 1'b0;
      r_kdown  <= 1'b0;
      r_kleft  <= 1'b0;
      r_kright <= 1'b0;
    end else if (w_frame_error) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (w_byte == SC_BREAK) begin
        r_brk <= 1'b1;
      end else begin
        // Any final code ends the prefix sequence, recognised or not.
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (r_ext) begin
          case (w_byte)
            SC_UP:    r_kup    <= ~r_brk;
            SC_DOWN:  r_kdown  <= ~r_brk;
            SC_LEFT:  r_kleft  <= ~r_brk;
            SC_RIGHT: r_kright <= ~r_brk;
            default:  ;
          endcase
        end else if (w_byte == SC_BAT) begin
          r_kup    <= 1'b0;
          r_kdown  <= 1'b0;
          r_kleft  <= 1'b0;
          r_kright <= 1'b0;
        end
      end
    end
  end

  assign kup         = r_kup;
  assign kdown       = r_kdown;
  assign kleft       = r_kleft;
  assign kright      = r_kright;
  assign frame_error = w_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_arrow_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_arrow_decoder
// Brief    : Directed self-checking bench; 1 us clock so a 60 us PS/2 bit is 60 clocks.
// Revision : 1.0
// ============================================================================
module tb_ps2_arrow_decoder;

  localparam int FL   = 8;
  localparam int TO   = 200;
  localparam int HALF = 30;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic kup, kdown, kleft, kright, frame_error;

  int n_tests    = 0;
  int n_fail     = 0;
  int err_cycles = 0;

  ps2_arrow_decoder #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .kup         (kup),
    .kdown       (kdown),
    .kleft       (kleft),
    .kright      (kright),
    .frame_error (frame_error)
  );

  always #500 clock = ~clock;

  always @(negedge clock) begin
    if (frame_error) err_cycles++;
  end

  function automatic logic [3:0] keys();
    return {kup, kdown, kleft, kright};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set while the clock is high, then a 30-clock low phase.
  task automatic send_bit(input logic b, input logic lat_chk);
    ps2_data = b;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b0;
    if (lat_chk) begin
      repeat (FL + 3) @(posedge clock);
      #1 chk("latency_before", 32'(kup), 32'd0);
      @(posedge clock);
      #1 chk("latency_at", 32'(kup), 32'd1);
      repeat (HALF - FL - 3) @(negedge clock);
    end else begin
      repeat (HALF) @(negedge clock);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic lat_chk);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, lat_chk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  initial begin
    repeat (5) @(negedge clock);
    chk("reset_held_keys", 32'(keys()), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("reset_keys", 32'(keys()), 32'h0);
    chk("reset_frame_error", 32'(frame_error), 32'd0);

    send_frame(8'hE0, 1'b0, 1'b0);
    chk("e0_only", 32'(keys()), 32'h0);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("up_make", 32'(keys()), 32'h8);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("up_break", 32'(keys()), 32'h0);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("up_make_again", 32'(keys()), 32'h8);
    send_partial(8'h6B, 4);
    reset = 1'b1;
    #1 chk("reset_midframe_keys", 32'(keys()), 32'h0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    chk("left_make", 32'(keys()), 32'h2);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    chk("left_right_held", 32'(keys()), 32'h3);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    chk("left_break", 32'(keys()), 32'h1);
    send_frame(8'hAA, 1'b0, 1'b0);
    chk("bat_clear", 32'(keys()), 32'h0);

    send_frame(8'h75, 1'b0, 1'b0);
    chk("keypad8_ignored", 32'(keys()), 32'h0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b0, 1'b0);
    chk("nonext_break", 32'(keys()), 32'h0);
    chk("no_errors_yet", 32'(err_cycles), 32'd0);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b1, 1'b0);
    chk("parity_err_pulse", 32'(err_cycles), 32'd1);
    chk("parity_err_keys", 32'(keys()), 32'h0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("prefix_cleared", 32'(keys()), 32'h0);

    send_partial(8'h00, 4);
    repeat (TO + 40) @(negedge clock);
    chk("timeout_pulse", 32'(err_cycles), 32'd2);
    chk("timeout_err_low", 32'(frame_error), 32'd0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b0, 1'b0);
    chk("down_make", 32'(keys()), 32'h4);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b0, 1'b0);
    chk("down_typematic", 32'(keys()), 32'h4);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("break_not_held", 32'(keys()), 32'h4);
    chk("final_err_count", 32'(err_cycles), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
